// File: rtl/nes_gamepad_reader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nes_gamepad_reader_if                                                |
// | Poll request, controller wires and decoded button result bundle.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface nes_gamepad_reader_if;
   logic       i_poll;
   logic       i_data;
   logic       o_latch;
   logic       o_pulse;
   logic [7:0] o_buttons;
   logic       o_valid;
   logic       o_busy;

   modport master (
      input  i_poll,
      input  i_data,
      output o_latch,
      output o_pulse,
      output o_buttons,
      output o_valid,
      output o_busy
   );

   modport slave (
      output i_poll,
      output i_data,
      input  o_latch,
      input  o_pulse,
      input  o_buttons,
      input  o_valid,
      input  o_busy
   );
endinterface
`default_nettype wire

// File: rtl/nes_gamepad_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nes_gamepad_reader                                                   |
// | Polls a 4021-based NES pad and publishes the 8 buttons active-high.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module nes_gamepad_reader #(
   parameter int CLK_FREQ       = 27_000_000,
   parameter int HALF_PERIOD_US = 6
) (
   input  wire logic             i_clk,
   input  wire logic             i_rst,
   nes_gamepad_reader_if.master  bus
);

   localparam int c_T     = (CLK_FREQ / 1_000_000) * HALF_PERIOD_US;
   localparam int c_CNT_W = $clog2(2 * c_T);
   localparam logic [c_CNT_W-1:0] c_LATCH_LAST = c_CNT_W'(2 * c_T - 1);
   localparam logic [c_CNT_W-1:0] c_PHASE_LAST = c_CNT_W'(c_T - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LATCH = 3'd1,
      S_LOW   = 3'd2,
      S_PULSE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t             state_q;
   logic [c_CNT_W-1:0] cnt_q;
   logic [2:0]         idx_q;
   logic [7:0]         shadow_q;
   logic [7:0]         shadow_d;
   logic               sync1_q;
   logic               sync2_q;
   logic               poll_q;
   logic               latch_q;
   logic               pulse_q;
   logic [7:0]         buttons_q;
   logic               valid_q;
   logic               busy_q;
   logic               poll_rise;

   assign poll_rise = bus.i_poll & ~poll_q;

   // Pad data is active-low; store it inverted so 1 = pressed.
   always_comb begin
      shadow_d        = shadow_q;
      shadow_d[idx_q] = ~sync2_q;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         shadow_q  <= '0;
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         poll_q    <= 1'b0;
         latch_q   <= 1'b0;
         pulse_q   <= 1'b0;
         buttons_q <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         sync1_q <= bus.i_data;
         sync2_q <= sync1_q;
         poll_q  <= bus.i_poll;
         valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (poll_rise) begin
                  state_q <= S_LATCH;
                  cnt_q   <= '0;
                  idx_q   <= '0;
                  latch_q <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            S_LATCH: begin
               if (cnt_q == c_LATCH_LAST) begin
                  state_q <= S_LOW;
                  cnt_q   <= '0;
                  latch_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + c_CNT_ONE;
               end
            end
            S_LOW: begin
               if (cnt_q == c_PHASE_LAST) begin
                  cnt_q    <= '0;
                  shadow_q <= shadow_d;
                  if (idx_q == 3'd7) begin
                     // Publish the complete byte at once, including the final bit.
                     state_q   <= S_DONE;
                     buttons_q <= shadow_d;
                     valid_q   <= 1'b1;
                  end else begin
                     state_q <= S_PULSE;
                     pulse_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + c_CNT_ONE;
               end
            end
            S_PULSE: begin
               if (cnt_q == c_PHASE_LAST) begin
                  state_q <= S_LOW;
                  cnt_q   <= '0;
                  idx_q   <= idx_q + 3'd1;
                  pulse_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + c_CNT_ONE;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               latch_q <= 1'b0;
               pulse_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_latch   = latch_q;
   assign bus.o_pulse   = pulse_q;
   assign bus.o_buttons = buttons_q;
   assign bus.o_valid   = valid_q;
   assign bus.o_busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_nes_gamepad_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_nes_gamepad_reader                                                |
// | Timeline-model checker for the NES pad reader (T = 12 cycles).       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_nes_gamepad_reader;
   localparam int T    = 12;
   localparam int MAXC = 32768;

   logic       clk       = 1'b0;
   logic       rst       = 1'b1;
   logic       poll      = 1'b0;
   logic       man_data  = 1'b1;
   logic       ctrl_en   = 1'b0;
   logic       ctrl_data = 1'b1;
   logic [7:0] pat       = 8'h00;

   always #5 clk = ~clk;

   nes_gamepad_reader_if bus();
   assign bus.i_poll = poll;
   assign bus.i_data = ctrl_en ? ctrl_data : man_data;

   nes_gamepad_reader #(
      .CLK_FREQ       (2_000_000),
      .HALF_PERIOD_US (6)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus.master)
   );

   // Pad model: latch reloads, each pulse rising edge advances one bit.
   int   cidx       = 0;
   logic prev_pulse = 1'b0;
   always @(posedge clk) begin
      #2;
      if (bus.o_latch) cidx = 0;
      else if (bus.o_pulse && !prev_pulse && cidx < 8) cidx = cidx + 1;
      prev_pulse = bus.o_pulse;
      ctrl_data  = (cidx < 8) ? ~pat[cidx] : 1'b1;
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   int         cyc = 0, chk = 0, err = 0, k = -1;
   int         pulse_rises = 0, valid_cnt = 0;
   logic       known = 1'b0, prev_poll = 1'b0, rst_prev = 1'b0, last_pulse = 1'b0;
   logic [7:0] exp_btn = 8'h00;
   logic       data_h [MAXC];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk++;
      if (act !== exp) begin
         err++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Button n is the inverted pin level two cycles before its sample cycle.
   function automatic logic [7:0] decode(input int kk);
      logic [7:0] b;
      for (int n = 0; n < 8; n++)
         b[n] = ~data_h[(kk + 2*T + (2*n + 1)*T - 2) % MAXC];
      return b;
   endfunction

   task automatic model_step();
      int   r, u;
      logic el, ep, ev, eb;
      if (rst_prev) begin
         known   = 1'b1;
         k       = -1;
         exp_btn = 8'h00;
      end else if (k >= 0 && cyc - k > 17*T + 1) begin
         k = -1;
      end
      el = 1'b0; ep = 1'b0; ev = 1'b0; eb = 1'b0;
      if (k >= 0) begin
         r  = cyc - k;
         u  = r - 2*T - 1;
         el = (r >= 1 && r <= 2*T);
         ep = (u >= 0 && u < 14*T && ((u / T) % 2 == 1));
         ev = (r == 17*T + 1);
         eb = (r >= 1 && r <= 17*T + 1);
         if (ev) exp_btn = decode(k);
      end
      if (known)
         check("outputs{latch,pulse,valid,busy,buttons}",
               {bus.o_latch, bus.o_pulse, bus.o_valid, bus.o_busy, bus.o_buttons},
               {el, ep, ev, eb, exp_btn});
      if (bus.o_pulse && !last_pulse) pulse_rises++;
      last_pulse = bus.o_pulse;
      if (bus.o_valid) valid_cnt++;
      data_h[cyc % MAXC] = bus.i_data;
      if (!rst && k < 0 && poll && !prev_poll) k = cyc;
      prev_poll = rst ? 1'b0 : poll;
      rst_prev  = rst;
   endtask

   task automatic tick();
      @(negedge clk);
      model_step();
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic wait_valid(input int maxc, output int at);
      int n;
      at = -1;
      n  = 0;
      while (at < 0 && n < maxc) begin
         if (bus.o_valid === 1'b1) at = cyc;
         else begin
            tick();
            n++;
         end
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (bus.o_busy !== 1'b0 && n < 400) begin
         tick();
         n++;
      end
      tick();
   endtask

   task automatic run_txn(output int lat);
      int e, at;
      poll = 1'b1;
      e    = cyc;
      tick();
      poll = 1'b0;
      wait_valid(400, at);
      lat = (at < 0) ? -1 : at - e;
   endtask

   typedef struct {
      logic [7:0] pat;
      logic [7:0] exp;
   } vec_t;
   vec_t vecs [6];

   initial begin
      int lat, at, e, n, v0, p0;
      vecs[0] = '{8'hA6, 8'hA6};
      vecs[1] = '{8'h00, 8'h00};
      vecs[2] = '{8'hFF, 8'hFF};
      vecs[3] = '{8'h01, 8'h01};
      vecs[4] = '{8'h80, 8'h80};
      vecs[5] = '{8'h5A, 8'h5A};

      // Reset state and latch timing
      rst = 1'b1; poll = 1'b0;
      repeat (3) tick();
      check("reset_state", {bus.o_latch, bus.o_pulse, bus.o_valid, bus.o_busy, bus.o_buttons}, 0);
      rst = 1'b0;
      tick();
      poll = 1'b1;
      check("latch_before_edge", bus.o_latch, 0);
      tick();
      check("latch_rise", bus.o_latch, 1);
      n = 0;
      while (bus.o_latch === 1'b1 && n < 100) begin
         n++;
         tick();
      end
      check("latch_width", n, 24);
      poll = 1'b0;
      wait_valid(400, at);
      check("first_txn_done", at >= 0, 1);

      // Table-driven decode via the pad model
      ctrl_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         pat = vecs[i].pat;
         wait_idle();
         v0 = valid_cnt;
         p0 = pulse_rises;
         run_txn(lat);
         check("valid_latency", lat, 205);
         check("buttons", bus.o_buttons, vecs[i].exp);
         repeat (3) tick();
         check("valid_once", valid_cnt - v0, 1);
         check("pulse_count", pulse_rises - p0, 7);
      end

      // Random patterns
      for (int i = 0; i < 8; i++) begin
         pat = 8'($urandom);
         wait_idle();
         run_txn(lat);
         check("rand_latency", lat, 205);
         check("rand_buttons", bus.o_buttons, pat);
      end

      // Poll while busy is ignored; poll in first idle cycle is taken
      pat = 8'h3C;
      wait_idle();
      v0 = valid_cnt;
      poll = 1'b1;
      e = cyc;
      tick();
      poll = 1'b0;
      while (cyc < e + 50) tick();
      poll = 1'b1;
      tick();
      poll = 1'b0;
      wait_valid(400, at);
      check("busy_poll_latency", at - e, 205);
      tick();
      poll = 1'b1;
      tick();
      check("restart_after_done", bus.o_busy, 1);
      check("busy_poll_valid_once", valid_cnt - v0, 1);
      poll = 1'b0;
      wait_valid(400, at);
      check("restart_buttons", bus.o_buttons, 8'h3C);

      // Reset during the 4th pulse
      pat = 8'hC3;
      wait_idle();
      p0 = pulse_rises;
      poll = 1'b1;
      tick();
      poll = 1'b0;
      n = 0;
      while (pulse_rises - p0 < 4 && n < 400) begin
         tick();
         n++;
      end
      check("reached_pulse4", pulse_rises - p0, 4);
      check("in_pulse4", bus.o_pulse, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_mid_pulse", bus.o_pulse, 0);
      check("rst_mid_busy", bus.o_busy, 0);
      check("rst_mid_buttons", bus.o_buttons, 8'h00);
      v0 = valid_cnt;
      repeat (300) tick();
      check("no_valid_after_rst", valid_cnt - v0, 0);

      // Synchronizer latency around the bit-0 sample point
      ctrl_en = 1'b0;
      man_data = 1'b1;
      wait_idle();
      poll = 1'b1;
      e = cyc;
      tick();
      poll = 1'b0;
      while (cyc < e + 3*T - 1) tick();
      man_data = 1'b0;
      wait_valid(400, at);
      check("jitter_late_change", bus.o_buttons, 8'hFE);
      man_data = 1'b1;
      wait_idle();
      poll = 1'b1;
      e = cyc;
      tick();
      poll = 1'b0;
      while (cyc < e + 3*T - 3) tick();
      man_data = 1'b0;
      wait_valid(400, at);
      check("jitter_early_change", bus.o_buttons, 8'hFF);

      // Random poll/data/reset activity against the timeline model
      for (int b = 0; b < 8; b++) begin
         ctrl_en = 1'($urandom_range(0, 1));
         pat     = 8'($urandom);
         for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 19) == 0) poll = ~poll;
            if ($urandom_range(0, 3) == 0) man_data = ~man_data;
            rst = ($urandom_range(0, 599) == 0);
            tick();
         end
      end
      rst = 1'b0;
      poll = 1'b0;
      repeat (5) tick();

      $display("Result: errors=%0d of %0d checks", err, chk);
      $finish;
   end
endmodule
`default_nettype wire
